mprf_sb: RTL

Load scoreboard and issue gate for the multi-port register file. It tracks architectural registers with membuf loads in flight and grants issue, in order, to the EXEC_LEN alu/alu_mul lanes. A lane is granted only when its register-file reads and writes are hazard-free. It sits between the decode/issue stage and the alu lanes, and observes the same `mem_sel` write-back the register file consumes.

---
 rtl/mprf_sb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mprf_sb.sv
// Load scoreboard and in-order issue gate for the multi-port register file.
// Counts membuf loads in flight per register and grants a hazard-free prefix of lanes.
module mprf_sb #(
  parameter int unsigned EXEC_LEN = 2,
  parameter int unsigned CW       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXEC_LEN-1:0]   issue_vld,
  input  logic [EXEC_LEN*5-1:0] issue_rs0,
  input  logic [EXEC_LEN*5-1:0] issue_rs1,
  input  logic [EXEC_LEN*5-1:0] issue_rd,
  input  logic [EXEC_LEN-1:0]   issue_ld,
  output logic [EXEC_LEN-1:0]   issue_ok,
  input  logic [4:0]            mem_sel,
  input  logic                  flush,
  output logic [31:0]           ld_pend,
  output logic [5:0]            pend_total,
  output logic                  sb_err
);

  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned TW   = 6;
  localparam int unsigned SW   = 8;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [SW-1:0] TMAX = SW'(63);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [31:0]   pend_q, pend_d;
  logic [TW-1:0] tot_q, tot_d;
  logic          err_q, err_d;

  logic          g_run, g_blk;
  logic [RW-1:0] g_rs0, g_rs1, g_rd, g_prd;
  logic [RW-1:0] n_rd;
  logic [SW-1:0] inc_r, sum_r, tot_inc, tot_dec, tsum;
  logic          dec_r;

  // Grant: prefix of lanes free of RAW/WAW on pending loads and intra-group load hazards.
  always_comb begin
    issue_ok = '0;
    g_run    = ~(rst | flush);
    g_blk    = 1'b0;
    g_rs0    = '0;
    g_rs1    = '0;
    g_rd     = '0;
    g_prd    = '0;
    for (int n = 0; n < EXEC_LEN; n++) begin
      g_rs0 = issue_rs0[n*RW +: RW];
      g_rs1 = issue_rs1[n*RW +: RW];
      g_rd  = issue_rd[n*RW +: RW];
      g_blk = ~issue_vld[n];
      if (g_rs0 != '0 && cnt_q[g_rs0] != '0) g_blk = 1'b1;
      if (g_rs1 != '0 && cnt_q[g_rs1] != '0) g_blk = 1'b1;
      // Multiple loads may stack on one rd; only an alu write would be clobbered.
      if (!issue_ld[n] && g_rd != '0 && cnt_q[g_rd] != '0) g_blk = 1'b1;
      if (issue_ld[n] && g_rd != '0 && cnt_q[g_rd] == CMAX) g_blk = 1'b1;
      for (int m = 0; m < n; m++) begin
        g_prd = issue_rd[m*RW +: RW];
        if (issue_ld[m] && g_prd != '0 &&
            (g_prd == g_rs0 || g_prd == g_rs1 || g_prd == g_rd)) g_blk = 1'b1;
      end
      g_run       = g_run & ~g_blk;
      issue_ok[n] = g_run;
    end
  end

  // Counter, total and error next state from accepted loads and the write-back.
  always_comb begin
    err_d   = err_q;
    tot_inc = '0;
    tot_dec = '0;
    inc_r   = '0;
    sum_r   = '0;
    dec_r   = 1'b0;
    n_rd    = '0;
    tsum    = '0;
    pend_d  = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_r = '0;
      for (int n = 0; n < EXEC_LEN; n++) begin
        n_rd = issue_rd[n*RW +: RW];
        if (issue_ok[n] && issue_ld[n] && n_rd == RW'(r)) inc_r = inc_r + SW'(1);
      end
      dec_r = (mem_sel == RW'(r));
      sum_r = SW'(cnt_q[r]) + inc_r;
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (dec_r && sum_r == '0) begin
        err_d    = 1'b1;
        cnt_d[r] = '0;
      end else begin
        if (dec_r) begin
          sum_r   = sum_r - SW'(1);
          tot_dec = tot_dec + SW'(1);
        end
        if (sum_r > SW'(CMAX)) begin
          sum_r = SW'(CMAX);
          err_d = 1'b1;
        end
        cnt_d[r] = CW'(sum_r);
        tot_inc  = tot_inc + inc_r;
      end
    end
    tsum = SW'(tot_q) + tot_inc;
    tsum = (tsum < tot_dec) ? '0 : tsum - tot_dec;
    if (tsum > TMAX) begin
      tsum  = TMAX;
      err_d = 1'b1;
    end
    tot_d = TW'(tsum);
    if (flush) begin
      for (int r = 0; r < NREG; r++) cnt_d[r] = '0;
      tot_d = '0;
      err_d = err_q;
    end
    for (int r = 0; r < NREG; r++) pend_d[r] = (cnt_d[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      pend_q <= '0;
      tot_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      pend_q <= pend_d;
      tot_q  <= tot_d;
      err_q  <= err_d;
    end
  end

  assign ld_pend    = pend_q;
  assign pend_total = tot_q;
  assign sb_err     = err_q;

endmodule
